// File: rtl/au_seq.sv
// au_seq: registered arithmetic unit for the datapath between the register
// file and writeback/flag logic. Single-cycle ADD/SUB/ADC/SBC/CMP/NOP and a
// WIDTH-cycle unsigned shift-and-add multiply, with a start/busy/done handshake.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   start          request, sampled only while busy=0
//   op[2:0]        000 ADD, 001 SUB, 010 ADC, 011 SBC, 100 MUL, 101 CMP, 11x NOP
//   a, b           WIDTH-bit operands
//   res            registered result (low product half for MUL)
//   res_hi         registered high product half (MUL only)
//   busy           multiply in progress
//   done           one-cycle completion pulse
//   c, v, n, z     registered carry, signed overflow, negative, zero flags
//   lt             signed less-than, n ^ v
module au_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res,
   output logic [WIDTH-1:0] res_hi,
   output logic             busy,
   output logic             done,
   output logic             c,
   output logic             v,
   output logic             n,
   output logic             z,
   output logic             lt
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] MUL_RUN = 1'b1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_ADC = 3'b010;
   localparam logic [2:0] OP_SBC = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_CMP = 3'b101;

   // Returns {carry_out, overflow, sum}. Overflow is carry into the MSB xor
   // carry out of it, so the low WIDTH-1 bits are summed separately.
   function automatic logic [WIDTH+1:0] add_cv(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             cin);
      logic [WIDTH:0]   full;
      logic [WIDTH-1:0] low;
      full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
      low  = {1'b0, x[WIDTH-2:0]} + {1'b0, y[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, cin};
      return {full[WIDTH], full[WIDTH] ^ low[WIDTH-1], full[WIDTH-1:0]};
   endfunction

   logic [0:0]       state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH+1:0] alu_out;
   logic [WIDTH-1:0] alu_sum;
   logic [WIDTH:0]   step_sum;
   logic [WIDTH-1:0] nxt_hi;
   logic [WIDTH-1:0] nxt_lo;

   // Subtract forms use a + ~b + cin; SBC's cin is the stored carry (1 = no borrow).
   always_comb begin
      alu_out = '0;
      case (op)
         OP_ADD:         alu_out = add_cv(a, b, 1'b0);
         OP_SUB, OP_CMP: alu_out = add_cv(a, ~b, 1'b1);
         OP_ADC:         alu_out = add_cv(a, b, c);
         OP_SBC:         alu_out = add_cv(a, ~b, c);
         default:        alu_out = '0;
      endcase
   end
   assign alu_sum = alu_out[WIDTH-1:0];

   // One shift-add step: conditionally add the multiplicand into the upper
   // half (keeping its carry), then shift the whole 2*WIDTH accumulator right.
   always_comb begin
      step_sum = {1'b0, acc_hi} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
      nxt_hi   = step_sum[WIDTH:1];
      nxt_lo   = {step_sum[0], acc_lo[WIDTH-1:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         res    <= '0;
         res_hi <= '0;
         c      <= 1'b0;
         v      <= 1'b0;
         n      <= 1'b0;
         z      <= 1'b0;
         done   <= 1'b0;
         mcand  <= '0;
         mplier <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  case (op)
                     OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                        res  <= alu_sum;
                        c    <= alu_out[WIDTH+1];
                        v    <= alu_out[WIDTH];
                        n    <= alu_sum[WIDTH-1];
                        z    <= (alu_sum == '0);
                        done <= 1'b1;
                     end
                     OP_CMP: begin
                        c    <= alu_out[WIDTH+1];
                        v    <= alu_out[WIDTH];
                        n    <= alu_sum[WIDTH-1];
                        z    <= (alu_sum == '0);
                        done <= 1'b1;
                     end
                     OP_MUL: begin
                        state  <= MUL_RUN;
                        mcand  <= a;
                        mplier <= b;
                        acc_hi <= '0;
                        acc_lo <= '0;
                        cnt    <= CNT_INIT;
                     end
                     default: done <= 1'b1;
                  endcase
               end
            end
            default: begin
               acc_hi <= nxt_hi;
               acc_lo <= nxt_lo;
               mplier <= mplier >> 1;
               cnt    <= cnt - CNT_LAST;
               // Final iteration: commit the just-computed product directly.
               if (cnt == CNT_LAST) begin
                  res    <= nxt_lo;
                  res_hi <= nxt_hi;
                  c      <= (nxt_hi != '0);
                  v      <= 1'b0;
                  n      <= nxt_hi[WIDTH-1];
                  z      <= ({nxt_hi, nxt_lo} == '0);
                  done   <= 1'b1;
                  state  <= IDLE;
               end
            end
         endcase
      end
   end

   assign busy = (state == MUL_RUN);
   assign lt   = n ^ v;

endmodule

// File: tb/tb_au_seq.sv
// tb_au_seq: directed test of au_seq at WIDTH 8, 16 and 32. One shared
// stimulus bus drives whichever instance is selected by 'sel'; outputs of the
// selected instance are muxed onto common observation signals.
module tb_au_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   int          sel;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, ADC = 3'b010, SBC = 3'b011;
   localparam logic [2:0] MUL = 3'b100, CMP = 3'b101, NOP = 3'b110;

   logic [7:0]  res8,  hi8;
   logic [15:0] res16, hi16;
   logic [31:0] res32, hi32;
   logic busy8, done8, c8, v8, n8, z8, lt8;
   logic busy16, done16, c16, v16, n16, z16, lt16;
   logic busy32, done32, c32, v32, n32, z32, lt32;
   logic start8, start16, start32;

   assign start8  = start && (sel == 8);
   assign start16 = start && (sel == 16);
   assign start32 = start && (sel == 32);

   au_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]),
      .res(res8), .res_hi(hi8), .busy(busy8), .done(done8),
      .c(c8), .v(v8), .n(n8), .z(z8), .lt(lt8));

   au_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .op(op), .a(a[15:0]), .b(b[15:0]),
      .res(res16), .res_hi(hi16), .busy(busy16), .done(done16),
      .c(c16), .v(v16), .n(n16), .z(z16), .lt(lt16));

   au_seq #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .start(start32), .op(op), .a(a), .b(b),
      .res(res32), .res_hi(hi32), .busy(busy32), .done(done32),
      .c(c32), .v(v32), .n(n32), .z(z32), .lt(lt32));

   // Observed outputs of the selected instance; flags packed {c,v,n,z,lt}.
   logic [63:0] o_res, o_hi;
   logic [4:0]  o_flags;
   logic        o_busy, o_done;

   always_comb begin
      o_res = '0; o_hi = '0; o_flags = '0; o_busy = 1'b0; o_done = 1'b0;
      case (sel)
         8: begin
            o_res = {56'b0, res8}; o_hi = {56'b0, hi8};
            o_flags = {c8, v8, n8, z8, lt8}; o_busy = busy8; o_done = done8;
         end
         32: begin
            o_res = {32'b0, res32}; o_hi = {32'b0, hi32};
            o_flags = {c32, v32, n32, z32, lt32}; o_busy = busy32; o_done = done32;
         end
         default: begin
            o_res = {48'b0, res16}; o_hi = {48'b0, hi16};
            o_flags = {c16, v16, n16, z16, lt16}; o_busy = busy16; o_done = done16;
         end
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request before edge k; return #1 after edge k.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic single(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] exp_res,
                         input logic [4:0] exp_flags);
      issue(o, x, y);
      chk({tag, " done"}, {63'b0, o_done}, 64'd1);
      chk({tag, " res"}, o_res, exp_res);
      chk({tag, " flags"}, {59'b0, o_flags}, {59'b0, exp_flags});
      chk({tag, " busy"}, {63'b0, o_busy}, 64'd0);
   endtask

   task automatic mul(input string tag, input logic [31:0] x, input logic [31:0] y,
                      input int w, input logic [63:0] exp_lo, input logic [63:0] exp_hi,
                      input logic [4:0] exp_flags, input bit poke);
      int  cyc;
      bit  got;
      bit  busy_ok;
      issue(MUL, x, y);
      chk({tag, " busy after start"}, {63'b0, o_busy}, 64'd1);
      chk({tag, " no early done"}, {63'b0, o_done}, 64'd0);
      cyc = 0; got = 1'b0; busy_ok = 1'b1;
      while (!got && cyc < w + 4) begin
         if (poke && cyc == 4) begin
            @(negedge clk);
            start = 1'b1; op = ADD; a = 32'd1; b = 32'd1;
            @(posedge clk);
            #1;
            start = 1'b0;
         end else begin
            step();
         end
         cyc++;
         if (o_done) got = 1'b1;
         else if (!o_busy) busy_ok = 1'b0;
      end
      chk({tag, " latency"}, 64'(cyc), 64'(w));
      chk({tag, " busy held"}, {63'b0, busy_ok}, 64'd1);
      chk({tag, " busy at done"}, {63'b0, o_busy}, 64'd0);
      chk({tag, " res"}, o_res, exp_lo);
      chk({tag, " res_hi"}, o_hi, exp_hi);
      chk({tag, " flags"}, {59'b0, o_flags}, {59'b0, exp_flags});
      step();
      chk({tag, " done one cycle"}, {63'b0, o_done}, 64'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = ADD; a = '0; b = '0; sel = 16;
      repeat (2) @(posedge clk);
      #1;
      for (int w = 8; w <= 32; w = w * 2) begin
         sel = w;
         #1;
         chk("reset res", o_res, 64'd0);
         chk("reset res_hi", o_hi, 64'd0);
         chk("reset flags", {59'b0, o_flags}, 64'd0);
         chk("reset busy/done", {62'b0, o_busy, o_done}, 64'd0);
      end
      sel = 16;
      @(negedge clk);
      rst = 1'b0;

      // WIDTH=16 single-cycle ops
      single("w16 add ovf", ADD, 32'h7FFF, 32'h0001, 64'h8000, 5'b01100);
      single("w16 sub neg", SUB, 32'h0003, 32'h0005, 64'hFFFE, 5'b00101);
      single("w16 cmp eq", CMP, 32'h0005, 32'h0005, 64'hFFFE, 5'b10010);
      single("w16 add wrap", ADD, 32'hFFFF, 32'h0001, 64'h0000, 5'b10010);
      single("w16 adc c1", ADC, 32'h0000, 32'h0000, 64'h0001, 5'b00000);
      single("w16 sbc c0", SBC, 32'h0005, 32'h0003, 64'h0001, 5'b10000);
      single("w16 nop", NOP, 32'h1111, 32'h2222, 64'h0001, 5'b10000);
      step();
      chk("w16 nop done one cycle", {63'b0, o_done}, 64'd0);

      // WIDTH=16 multiplies
      mul("w16 mul", 32'h1234, 32'h0100, 16, 64'h3400, 64'h0012, 5'b10000, 1'b1);
      mul("w16 mul max", 32'hFFFF, 32'hFFFF, 16, 64'h0001, 64'hFFFE, 5'b10101, 1'b0);
      mul("w16 mul zero", 32'h0000, 32'h1234, 16, 64'h0000, 64'h0000, 5'b00010, 1'b0);

      // Reset in the middle of a multiply
      issue(MUL, 32'h1234, 32'h0100);
      repeat (5) step();
      #2 rst = 1'b1;
      #1;
      chk("rst mid busy", {63'b0, o_busy}, 64'd0);
      chk("rst mid res", o_res, 64'd0);
      chk("rst mid res_hi", o_hi, 64'd0);
      chk("rst mid flags", {59'b0, o_flags}, 64'd0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst mid no done", {62'b0, o_done, o_busy}, 64'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("post rst idle", {62'b0, o_done, o_busy}, 64'd0);
      single("w16 add after rst", ADD, 32'h0001, 32'h0001, 64'h0002, 5'b00000);

      // WIDTH=8
      sel = 8;
      single("w8 add ovf", ADD, 32'h7F, 32'h01, 64'h80, 5'b01100);
      mul("w8 mul", 32'h12, 32'h10, 8, 64'h20, 64'h01, 5'b10000, 1'b1);
      mul("w8 mul max", 32'hFF, 32'hFF, 8, 64'h01, 64'hFE, 5'b10101, 1'b0);

      // WIDTH=32
      sel = 32;
      single("w32 add ovf", ADD, 32'h7FFF_FFFF, 32'h1, 64'h8000_0000, 5'b01100);
      mul("w32 mul", 32'h1234_5678, 32'h0000_0100, 32, 64'h3456_7800, 64'h12, 5'b10000, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
